// File: rtl/lolap_pkg.sv
// LolaP shared definitions: state width, round-variant mask, round constant
// and the iterative-permutation FSM states.
package lolap_pkg;

    localparam int unsigned LOLAP_STATE_W = 257;

    // Bit r-1 set when forward round r carries the round-constant layer.
    localparam logic [7:0]  LOLAP_W_MASK  = 8'b1100_1101;

    localparam logic [63:0] LOLAP_RC_BASE = 64'hB7E1_5162_8AED_2A6A;

    typedef logic [LOLAP_STATE_W-1:0] lolap_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } lolap_fsm_e;

    // Round constant for forward round `round` (1..8): the base word rotated
    // left by the round number, with the round number folded into the low bits.
    function automatic logic [63:0] lolap_rc(input logic [3:0] round);
        logic [127:0] dbl;
        dbl = {LOLAP_RC_BASE, LOLAP_RC_BASE} << round;
        return dbl[127:64] ^ {60'd0, round};
    endfunction

endpackage

// File: rtl/lolap_inv_iter_if.sv
// Handshake bundle for lolap_inv_iter: input channel, output channel, status.
// Optional macro LOLAP_INV_FWD_EN adds the direction select dir_i.
interface lolap_inv_iter_if;
    import lolap_pkg::*;

    logic         in_valid_i;
    logic         in_ready_o;
    lolap_state_t state_i;
    logic         out_valid_o;
    logic         out_ready_i;
    lolap_state_t state_o;
    logic         busy_o;
`ifdef LOLAP_INV_FWD_EN
    logic         dir_i;
`endif

    modport master (
`ifdef LOLAP_INV_FWD_EN
        output dir_i,
`endif
        output in_valid_i, state_i, out_ready_i,
        input  in_ready_o, out_valid_o, state_o, busy_o
    );

    modport slave (
`ifdef LOLAP_INV_FWD_EN
        input  dir_i,
`endif
        input  in_valid_i, state_i, out_ready_i,
        output in_ready_o, out_valid_o, state_o, busy_o
    );

endinterface

// File: rtl/lolap_round_inv.sv
// Combinational LolaP round datapaths.
// lolap_round_inv: one inverse round (always built).
// lolap_round_fwd: one forward round, built only with LOLAP_INV_FWD_EN.
// Forward round order: constant layer, nonlinear layer, linear layer.
module lolap_round_inv
    import lolap_pkg::*;
(
    input  lolap_state_t state_i,
    input  logic         with_rc_i,
    input  logic [3:0]   round_i,
    output lolap_state_t state_o
);

    lolap_state_t unrot;
    lolap_state_t unmixed;
    logic [128:0] hi_mix;
    logic [127:0] lo_mix;
    logic [128:0] hi_in;
    logic [127:0] lo_in;

    // Undo linear layer: rotate right by 23.
    assign unrot  = {state_i[22:0], state_i[256:23]};
    assign hi_mix = unrot[256:128];
    assign lo_mix = unrot[127:0];

    // Undo the two Feistel-style nonlinear half-steps, last one first.
    assign hi_in   = hi_mix ^ {lo_mix[127], lo_mix & {lo_mix[124:0], lo_mix[127:125]}};
    assign lo_in   = lo_mix ^ (hi_in[127:0] & {hi_in[126:0], hi_in[127]});
    assign unmixed = {hi_in, lo_in};

    // Constant removed last, mirroring the forward order.
    assign state_o = with_rc_i ? {unmixed[256:64], unmixed[63:0] ^ lolap_rc(round_i)}
                               : unmixed;

endmodule

`ifdef LOLAP_INV_FWD_EN
module lolap_round_fwd
    import lolap_pkg::*;
(
    input  lolap_state_t state_i,
    input  logic         with_rc_i,
    input  logic [3:0]   round_i,
    output lolap_state_t state_o
);

    lolap_state_t keyed;
    lolap_state_t mixed;
    logic [128:0] hi_in;
    logic [127:0] lo_in;
    logic [128:0] hi_mix;
    logic [127:0] lo_mix;

    assign keyed  = with_rc_i ? {state_i[256:64], state_i[63:0] ^ lolap_rc(round_i)}
                              : state_i;
    assign hi_in  = keyed[256:128];
    assign lo_in  = keyed[127:0];
    assign lo_mix = lo_in ^ (hi_in[127:0] & {hi_in[126:0], hi_in[127]});
    assign hi_mix = hi_in ^ {lo_mix[127], lo_mix & {lo_mix[124:0], lo_mix[127:125]}};
    assign mixed  = {hi_mix, lo_mix};

    // Linear layer: rotate left by 23.
    assign state_o = {mixed[233:0], mixed[256:234]};

endmodule
`endif

// File: rtl/lolap_inv_iter.sv
// Iterative LolaP inverse permutation: one round per clock, rounds applied
// in reverse order, valid/ready on both sides.
// Optional macro LOLAP_INV_FWD_EN adds dir_i (sampled at accept); dir_i=1 runs
// the forward rounds 1..NR_ROUNDS instead.
module lolap_inv_iter
    import lolap_pkg::*;
#(
    parameter int unsigned NR_ROUNDS = 8
)
(
    input  logic             clk,
    input  logic             rst,
    lolap_inv_iter_if.slave  bus
);

    if (NR_ROUNDS < 1 || NR_ROUNDS > 8) begin : g_bad_rounds
        $error("lolap_inv_iter: NR_ROUNDS must be in 1..8");
    end

    localparam int unsigned CNT_W = (NR_ROUNDS > 1) ? $clog2(NR_ROUNDS) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(NR_ROUNDS - 1);

    lolap_fsm_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    lolap_state_t     data_q, data_d;

    logic [3:0]       round_num;
    logic [2:0]       rc_idx;
    logic             with_rc;
    lolap_state_t     inv_out;
    lolap_state_t     step_out;

`ifdef LOLAP_INV_FWD_EN
    logic             dir_q, dir_d;
    lolap_state_t     fwd_out;

    assign round_num = dir_q ? (4'(cnt_q) + 4'd1) : (4'(NR_ROUNDS) - 4'(cnt_q));
    assign step_out  = dir_q ? fwd_out : inv_out;

    lolap_round_fwd u_round_fwd (
        .state_i   (data_q),
        .with_rc_i (with_rc),
        .round_i   (round_num),
        .state_o   (fwd_out)
    );
`else
    assign round_num = 4'(NR_ROUNDS) - 4'(cnt_q);
    assign step_out  = inv_out;
`endif

    assign rc_idx  = 3'(round_num - 4'd1);
    assign with_rc = LOLAP_W_MASK[rc_idx];

    lolap_round_inv u_round_inv (
        .state_i   (data_q),
        .with_rc_i (with_rc),
        .round_i   (round_num),
        .state_o   (inv_out)
    );

    assign bus.state_o = data_q;

    // State, step counter and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
`ifdef LOLAP_INV_FWD_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
`ifdef LOLAP_INV_FWD_EN
            dir_q   <= dir_d;
`endif
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        data_d          = data_q;
`ifdef LOLAP_INV_FWD_EN
        dir_d           = dir_q;
`endif
        bus.in_ready_o  = 1'b0;
        bus.out_valid_o = 1'b0;
        bus.busy_o      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                bus.in_ready_o = 1'b1;
                if (bus.in_valid_i) begin
                    data_d  = bus.state_i;
                    cnt_d   = '0;
                    state_d = ST_RUN;
`ifdef LOLAP_INV_FWD_EN
                    dir_d   = bus.dir_i;
`endif
                end
            end
            ST_RUN: begin
                bus.busy_o = 1'b1;
                data_d     = step_out;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.out_valid_o = 1'b1;
                if (bus.out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: doc/lolap_inv_iter.md
# lolap_inv_iter

Iterative inverse of the LolaP permutation on the 257-bit state. It applies one inverse round per clock, in reverse round order, behind valid/ready handshakes. It sits on the decrypt/unwrap path opposite the combinational forward permutation, and trades NR_ROUNDS cycles of latency for a single round datapath.

## Interface
Parameters:
- NR_ROUNDS, 8, number of forward rounds being inverted; legal range 1..8.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid_i  in  1  input state offered
- in_ready_o  out  1  block can accept a state
- state_i  in  257  permuted state (forward output)
- out_valid_o  out  1  result available
- out_ready_i  in  1  consumer takes result
- state_o  out  257  recovered state (forward input)
- busy_o  out  1  high while rounds are being applied

## Operation
- FSM states:
  - IDLE: in_ready_o=1. On in_valid_i && in_ready_o, load state_i into the state register, set the step counter to 0, and go to RUN.
  - RUN: each cycle apply inverse step k and increment k. Step k undoes forward round r = NR_ROUNDS−k (1-indexed). After step NR_ROUNDS−1, go to DONE.
  - DONE: out_valid_o=1 and state_o holds the result. On out_ready_i, go to IDLE.
- Round variant per step:
  - Forward rounds 1, 3, 4, 7, 8 are "with" rounds (round-constant layer); rounds 2, 5, 6 are "without".
  - The inverse step uses the inverse of the matching variant.
  - For a "with" round, undo the nonlinear/linear layers first, then the constant; that is, remove the constant after inverting the layers, exactly reversing forward order.
- Step counter width is $clog2(NR_ROUNDS) with a minimum of 1. It holds its value in IDLE and DONE.
- state_o is driven directly from the state register and is stable throughout DONE.
- in_valid_i is ignored outside IDLE; there is no buffering of a second input.
- in_ready_o is low in RUN and DONE. A new input is therefore accepted no earlier than the cycle after the DONE handshake.
- busy_o is high exactly when the FSM is in RUN.

## Timing
- Reset values: in_ready_o=1, out_valid_o=0, busy_o=0, state_o=0, FSM=IDLE, counter=0.
- Latency: with the accept edge at T, out_valid_o rises after edge T+NR_ROUNDS.
- Minimum period: NR_ROUNDS+2 cycles per state when out_ready_i is held high.
- Backpressure: out_valid_o and state_o hold indefinitely until out_ready_i is sampled high.
- If out_ready_i is high on the first DONE cycle, DONE lasts exactly one cycle.
- Reset asserted mid-RUN or in DONE: outputs return to their reset values immediately and the partial state is discarded.
- NR_ROUNDS=1: a single RUN cycle.
- Elaboration fails if NR_ROUNDS is outside 1..8.

## Configuration
- LOLAP_INV_FWD_EN:
  - Defined: adds input port dir_i (1 bit), sampled at accept. When dir_i=1, the block runs forward rounds 1..NR_ROUNDS in order, with variants from the same table, so it serves as a sequential forward permutation. When dir_i=0, it runs the inverse as above.
  - Undefined: the port is absent and the block is inverse-only.

## Structure
- Shared package lolap_pkg holds:
  - LOLAP_STATE_W = 257.
  - LOLAP_W_MASK = 8'b1100_1101 (bit r−1 set when forward round r is a "with" round).
  - The round-constant function.
  - The FSM state enum.
- Sub-module lolap_round_inv: combinational single inverse round, taking a state and a with_rc select. Under LOLAP_INV_FWD_EN, the forward round logic is instantiated alongside it and a mux selects between them.

## Test plan
- Round trip: state_i = forward(257'h0) with NR_ROUNDS=8 → state_o = 257'h0, with out_valid_o rising exactly 8 cycles after accept.
- Round trip on random vectors: 100 vectors of forward(x) → state_o == x. Repeat for NR_ROUNDS = 1, 3, 8.
- Backpressure: hold out_ready_i=0 for 20 cycles in DONE → state_o stable, in_ready_o=0, and an in_valid_i pulse during DONE is ignored.
- Back-to-back: in_valid_i and out_ready_i held at 1 → accepts spaced exactly 10 cycles apart for NR_ROUNDS=8.
- Reset mid-operation: assert rst on the 4th RUN cycle → next sample shows in_ready_o=1, out_valid_o=0, busy_o=0, state_o=0, and the following transfer is correct.
- With LOLAP_INV_FWD_EN: dir_i=1 on 257'h1 gives forward(257'h1); feeding that back with dir_i=0 returns 257'h1.
